// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display path.
// Holds the converter state encoding, sign/blank letter codes and BCD geometry.
package alu_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;

endpackage

// File: rtl/bcd_convert_seq_if.sv
// Request/result bundle between the ALU result path and the BCD converter.
// start is sampled only while busy=0; done is a one-cycle pulse marking new digits.
interface bcd_convert_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [3:0]       Ones;
    logic [3:0]       Tens;
    logic [3:0]       Hundreds;
    logic [3:0]       Letters;

    modport master (
        output start, bin_in,
        input  busy, done, Ones, Tens, Hundreds, Letters
    );

    modport slave (
        input  start, bin_in,
        output busy, done, Ones, Tens, Hundreds, Letters
    );
endinterface

// File: rtl/bcd_add3.sv
// One double-dabble correction step for a single BCD nibble:
// values of 5 or more get +3 so the following left shift carries into the next digit.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;
endmodule

// File: rtl/bcd_convert_seq.sv
// Iterative shift-add-3 binary-to-BCD converter with sign letter for the display mux.
// Digit outputs are registered and only move on the done pulse.
module bcd_convert_seq
    import alu_disp_pkg::*;
#(
    parameter int         WIDTH      = 8,
    parameter bit         SIGNED_IN  = 1'b1,
    parameter logic [3:0] CODE_MINUS = alu_disp_pkg::CODE_MINUS,
    parameter logic [3:0] CODE_BLANK = alu_disp_pkg::CODE_BLANK
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_convert_seq_if.slave    bus,
    output state_e              dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               done_q, done_d;
    logic [3:0]         ones_q, ones_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         hundreds_q, hundreds_d;
    logic [3:0]         letters_q, letters_d;
    logic [BCD_W+WIDTH-1:0] shifted;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (bcd_q[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    // Corrected digits and remaining magnitude shift as one register pair.
    assign shifted = {bcd_adj, mag_q} << 1;

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        done_d     = 1'b0;
        ones_d     = ones_q;
        tens_d     = tens_q;
        hundreds_d = hundreds_q;
        letters_d  = letters_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mag_d   = bus.bin_in;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct magnitude.
                sign_d  = SIGNED_IN && mag_q[WIDTH-1];
                mag_d   = sign_d ? -mag_q : mag_q;
                bcd_d   = '0;
                cnt_d   = CNT_W'(WIDTH);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                bcd_d = shifted[BCD_W+WIDTH-1 -: BCD_W];
                mag_d = shifted[WIDTH-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ones_d     = bcd_q[3:0];
                tens_d     = bcd_q[7:4];
                hundreds_d = bcd_q[11:8];
                letters_d  = sign_q ? CODE_MINUS : CODE_BLANK;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            done_q     <= 1'b0;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            hundreds_q <= 4'd0;
            letters_q  <= CODE_BLANK;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            done_q     <= done_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            hundreds_q <= hundreds_d;
            letters_q  <= letters_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.Ones     = ones_q;
    assign bus.Tens     = tens_q;
    assign bus.Hundreds = hundreds_q;
    assign bus.Letters  = letters_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Bench for bcd_convert_seq: signed and unsigned instances, vector table,
// hand-written handshake/reset sequences and a shuffled sweep of all inputs.
module tb_bcd_convert_seq;
    import alu_disp_pkg::*;

    logic   clk;
    logic   rst_n;
    state_e dbg_s, dbg_u;

    bcd_convert_seq_if #(.WIDTH(8)) if_s ();
    bcd_convert_seq_if #(.WIDTH(8)) if_u ();

    bcd_convert_seq #(.WIDTH(8), .SIGNED_IN(1'b1)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if_s),
        .dbg_state (dbg_s)
    );

    bcd_convert_seq #(.WIDTH(8), .SIGNED_IN(1'b0)) dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if_u),
        .dbg_state (dbg_u)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt_s = 0;
    int done_cnt_u = 0;
    logic [15:0] exp_s_q[$];
    logic [15:0] exp_u_q[$];

    typedef struct {
        bit          uns;
        logic [7:0]  bin;
        logic [15:0] exp;   // {Letters, Hundreds, Tens, Ones}
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_model(input logic [7:0] v, input bit uns);
        int val;
        bit neg;
        val = int'(v);
        neg = 1'b0;
        if (!uns && val >= 128) begin
            val = 256 - val;
            neg = 1'b1;
        end
        return {(neg ? 4'hA : 4'hF), 4'(val / 100), 4'((val / 10) % 10), 4'(val % 10)};
    endfunction

    function automatic logic [15:0] get_out(input bit uns);
        if (uns) return {if_u.Letters, if_u.Hundreds, if_u.Tens, if_u.Ones};
        return {if_s.Letters, if_s.Hundreds, if_s.Tens, if_s.Ones};
    endfunction

    function automatic logic get_done(input bit uns);
        return uns ? if_u.done : if_s.done;
    endfunction

    function automatic logic get_busy(input bit uns);
        return uns ? if_u.busy : if_s.busy;
    endfunction

    always @(negedge clk) begin
        if (rst_n && if_s.done) begin
            done_cnt_s++;
            if (exp_s_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done_s: got %0h expected no done at %0t", get_out(1'b0), $time);
            end else begin
                check("data_s", int'(get_out(1'b0)), int'(exp_s_q.pop_front()));
            end
        end
        if (rst_n && if_u.done) begin
            done_cnt_u++;
            if (exp_u_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done_u: got %0h expected no done at %0t", get_out(1'b1), $time);
            end else begin
                check("data_u", int'(get_out(1'b1)), int'(exp_u_q.pop_front()));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input bit uns, input logic [7:0] v, input logic st);
        if (uns) begin
            if_u.start  = st;
            if_u.bin_in = v;
        end else begin
            if_s.start  = st;
            if_s.bin_in = v;
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge of the done cycle.
    task automatic run_conv(input bit uns, input logic [7:0] v, input logic [15:0] exp);
        int lat;
        int busy_cyc;
        bit seen;
        check("idle_before_start", int'(get_busy(uns)), 0);
        if (uns) exp_u_q.push_back(exp);
        else     exp_s_q.push_back(exp);
        drive(uns, v, 1'b1);
        @(posedge clk);
        #1;
        drive(uns, 8'($urandom_range(0, 255)), 1'b0);
        seen = 1'b0;
        lat = 0;
        busy_cyc = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (get_done(uns)) begin
                seen = 1'b1;
                lat = i - 1;
            end else if (get_busy(uns)) begin
                busy_cyc++;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles for %0h", v);
        end else begin
            check("latency", lat, 10);
            check("busy_cycles", busy_cyc, 10);
            check("busy_at_done", int'(get_busy(uns)), 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int order[256];
        bit seen;

        vecs[0]  = '{1'b0, 8'h7F, 16'hF127};
        vecs[1]  = '{1'b0, 8'h80, 16'hA128};
        vecs[2]  = '{1'b0, 8'hFF, 16'hA001};
        vecs[3]  = '{1'b0, 8'h00, 16'hF000};
        vecs[4]  = '{1'b1, 8'hFF, 16'hF255};
        vecs[5]  = '{1'b0, 8'h63, 16'hF099};
        vecs[6]  = '{1'b0, 8'h9C, 16'hA100};
        vecs[7]  = '{1'b0, 8'hF6, 16'hA010};
        vecs[8]  = '{1'b1, 8'h64, 16'hF100};
        vecs[9]  = '{1'b1, 8'h80, 16'hF128};
        vecs[10] = '{1'b1, 8'h00, 16'hF000};
        vecs[11] = '{1'b0, 8'h05, 16'hF005};

        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_s", int'(get_out(1'b0)), 16'hF000);
        check("reset_out_u", int'(get_out(1'b1)), 16'hF000);
        check("reset_busy_s", int'(if_s.busy), 0);
        check("reset_done_s", int'(if_s.done), 0);
        check("reset_state_s", int'(dbg_s), int'(S_IDLE));
        check("reset_state_u", int'(dbg_u), int'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, issued back to back.
        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].uns, vecs[i].bin, vecs[i].exp);
        end

        // start while busy is ignored; bin_in changes after capture are ignored.
        @(negedge clk);
        d0 = done_cnt_s;
        exp_s_q.push_back(16'hF005);
        drive(1'b0, 8'h05, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h63, 1'b0);
        repeat (3) @(negedge clk);
        drive(1'b0, 8'h63, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h63, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (if_s.done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL busy_start_timeout: got no done expected one done");
        end
        @(negedge clk);
        run_conv(1'b0, 8'h63, 16'hF099);
        repeat (15) @(negedge clk);
        #1;
        check("done_count_busy_start", done_cnt_s - d0, 2);

        // Reset in the middle of SHIFT aborts without a done pulse.
        @(negedge clk);
        drive(1'b0, 8'h7F, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b0);
        repeat (5) @(negedge clk);
        check("state_shift", int'(dbg_s), int'(S_SHIFT));
        check("pre_abort_out", int'(get_out(1'b0)), 16'hF099);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out", int'(get_out(1'b0)), 16'hF000);
        check("abort_busy", int'(if_s.busy), 0);
        check("abort_done", int'(if_s.done), 0);
        check("abort_state", int'(dbg_s), int'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt_s;
        repeat (15) @(negedge clk);
        #1;
        check("no_done_after_abort", done_cnt_s - d0, 0);
        @(negedge clk);
        run_conv(1'b0, 8'h80, 16'hA128);

        // Shuffled sweep of every input on both instances against the model.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            run_conv(1'b0, 8'(order[i]), ref_model(8'(order[i]), 1'b0));
            run_conv(1'b1, 8'(order[255 - i]), ref_model(8'(order[255 - i]), 1'b1));
        end

        repeat (3) @(negedge clk);
        #1;
        check("queue_empty_s", exp_s_q.size(), 0);
        check("queue_empty_u", exp_u_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
